phy_rx_serial_parallel: RTL

- Receive-side counterpart of the PHY TX serializer.
- Samples the 1-bit serial stream on clk_32f and finds byte alignment by hunting for the COM character (8'hBC).
- Declares lock after BC_LOCK consecutive aligned COMs, then delivers de-serialized bytes with valid/strobe qualifiers and an IDLE indication.
- Sits between the serial link and the RX byte un-striper (lanes 0-3).

---
 rtl/phy_defs.sv | 15 +
 rtl/phy_rx_shifter.sv | 47 ++++
 rtl/phy_rx_serial_parallel.sv | 124 ++++++++++++
 3 files changed

// File: rtl/phy_defs.sv
// Shared PHY definitions: K-characters, lock threshold and the RX state encoding.
// The TX serializer imports the same package.
package phy_defs;

  localparam logic [7:0]  COM         = 8'hBC;
  localparam logic [7:0]  IDL         = 8'h7C;
  localparam int unsigned BC_LOCK_DEF = 4;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/phy_rx_shifter.sv
// Serial-in shift register plus the bit counter that marks aligned byte boundaries.
module phy_rx_shifter
  import phy_defs::*;
(
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  input  rx_state_e  state,
  input  logic       sync_load,
  output logic [7:0] sr,
  output logic       byte_ready
);

  logic [7:0] sr_q, sr_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       byte_ready_q, byte_ready_d;

  always_comb begin
    sr_d         = {data_in, sr_q[7:1]};
    bitcnt_d     = bitcnt_q;
    byte_ready_d = 1'b0;
    // The edge that leaves SEARCH already shifts in bit 0 of the next byte,
    // so the count starts at one to keep byte_ready on the true boundary.
    if (sync_load) begin
      bitcnt_d = 3'd1;
    end else if (state != ST_SEARCH) begin
      bitcnt_d     = bitcnt_q + 3'd1;
      byte_ready_d = (bitcnt_q == 3'd7);
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      sr_q         <= 8'h00;
      bitcnt_q     <= 3'd0;
      byte_ready_q <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      bitcnt_q     <= bitcnt_d;
      byte_ready_q <= byte_ready_d;
    end
  end

  assign sr         = sr_q;
  assign byte_ready = byte_ready_q;

endmodule

// File: rtl/phy_rx_serial_parallel.sv
// PHY RX deserializer: hunts for COM alignment, locks after BC_LOCK aligned COMs,
// then delivers bytes with valid/strobe/idle qualifiers.
//
// state  | meaning
// SEARCH | sliding-window hunt for COM at any bit phase
// ALIGN  | counting consecutive aligned COMs toward lock
// ACTIVE | locked; alignment fixed until reset, bytes delivered
module phy_rx_serial_parallel
  import phy_defs::*;
#(
  parameter int unsigned BC_LOCK = BC_LOCK_DEF
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active,
  output logic       idle_out
);

  localparam logic [3:0] LOCK_CNT = 4'(BC_LOCK);

  rx_state_e  state_q, state_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       strobe_q, strobe_d;
  logic       active_q, active_d;
  logic       idle_q, idle_d;
  logic       sync_load;
  logic [7:0] sr;
  logic       byte_ready;

  phy_rx_shifter u_shifter (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .state      (state_q),
    .sync_load  (sync_load),
    .sr         (sr),
    .byte_ready (byte_ready)
  );

  always_comb begin
    state_d   = state_q;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    idle_d    = idle_q;
    strobe_d  = 1'b0;
    sync_load = 1'b0;
    active_d  = (state_q == ST_ACTIVE);
    unique case (state_q)
      ST_SEARCH: begin
        if (sr == COM) begin
          sync_load = 1'b1;
          bc_cnt_d  = 4'd1;
          state_d   = (LOCK_CNT == 4'd1) ? ST_ACTIVE : ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (byte_ready) begin
          if (sr == COM) begin
            if (bc_cnt_q >= LOCK_CNT - 4'd1) begin
              bc_cnt_d = LOCK_CNT;
              state_d  = ST_ACTIVE;
            end else begin
              bc_cnt_d = bc_cnt_q + 4'd1;
            end
          end else begin
            bc_cnt_d = 4'd0;
            state_d  = ST_SEARCH;
          end
        end
      end
      ST_ACTIVE: begin
        if (byte_ready) begin
          strobe_d = 1'b1;
          if (sr == COM) begin
            valid_d = 1'b0;
            idle_d  = 1'b0;
          end else if (sr == IDL) begin
            valid_d = 1'b0;
            idle_d  = 1'b1;
          end else begin
            data_d  = sr;
            valid_d = 1'b1;
            idle_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_SEARCH;
      bc_cnt_q <= 4'd0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      active_q <= 1'b0;
      idle_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bc_cnt_q <= bc_cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
      active_q <= active_d;
      idle_q   <= idle_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = active_q;
  assign idle_out    = idle_q;

endmodule
